pcx_req_sched: RTL
==================

// Module: pcx_req_sched
// PURPOSE
// - Per-SPARC-core PCX request scheduler: selects which destination (L2 bank 0-3, IO=4) gets the next packet.
// - Tracks per-destination PCX queue credits; returns a credit on each active-high grant pcx_spc_grant_pa.
// - Sequences two-packet atomics (CAS) as back-to-back requests to one destination.
// - Sits between the core's outbound packet queues and the PCX request wires.
// PARAMETERS
// - NDEST     5  number of PCX destinations (bit 4 = IO)
// - CRED_MAX  2  PCX per-destination queue depth = credits at reset
// - CW        2  credit counter width, holds 0..CRED_MAX
// PORTS
// - rclk              in   1      clock, single domain
// - arst_l            in   1      reset, asynchronous, active-low
// - req_vld_q         in   NDEST  head packet pending per destination; several bits may be set
// - req_atom_q        in   NDEST  head packet for that destination is a 2-packet atomic
// - pcx_spc_grant_pa  in   NDEST  PCX grant, active high, one credit returned per set bit per cycle
// - sched_pop         out  NDEST  comb one-hot; pop head of that destination queue this cycle
// - spc_pcx_req_pq    out  NDEST  registered one-hot request to PCX
// - spc_pcx_atom_pq   out  1      registered; set on first packet of an atomic pair
// - sched_cred        out  NDEST*CW  current credit per destination (debug/perf)
// - sched_err_ovf     out  1      sticky; grant received with credit already at CRED_MAX
// BEHAVIOUR
// - Reset (async, any time, incl. mid-atomic): credits=CRED_MAX, state=IDLE, rr_ptr=0,
//   spc_pcx_req_pq=0, spc_pcx_atom_pq=0, sched_err_ovf=0; sched_pop=0 while arst_l low.
// - Eligibility of d in IDLE: req_vld_q[d] & (req_atom_q[d] ? cred[d]==CRED_MAX : cred[d]>=1).
// - Arbitration in IDLE: round-robin over eligible d, search starts at rr_ptr+1 mod NDEST;
//   winner w: sched_pop[w]=1 same cycle; spc_pcx_req_pq[w]=1 next cycle (1-cycle latency);
//   rr_ptr<=w. No eligible d -> sched_pop=0, req_pq=0 next cycle.
// - FSM IDLE -> ATOM2 when winner is atomic; spc_pcx_atom_pq=1 with first request.
// - ATOM2: no arbitration; second packet unconditionally requested to same w (atom_pq=0),
//   sched_pop[w]=1 again; credit reserved at issue, so never stalls; -> IDLE after 1 cycle.
// - At most one request bit set per cycle; at most 2 consecutive cycles to the same atomic dest.
// - Credit update per d, per cycle: cred += grant[d] - issue[d] (issue = sched_pop[d]).
//   Simultaneous grant and issue on d -> unchanged. Never decremented below 0 (guaranteed by
//   eligibility). Grant at CRED_MAX without issue -> saturate at CRED_MAX, set sched_err_ovf.
// - Grant for d while d is being issued with cred 0: not possible (issue needs cred>=1).
// - Credits reflect grants in the same cycle for eligibility? No: eligibility uses registered
//   cred only; a returned credit is usable the cycle after the grant.
// - req_vld_q/req_atom_q are don't-care in ATOM2; queue must hold the second atomic packet valid.
// STRUCTURE
// - Shared package pcx_sched_pkg: NDEST, CRED_MAX, CW, destination indices (L2B0..L2B3, IO=4),
//   state enum {IDLE, ATOM2}.
// - Sub-module pcx_cred_ctr (one per destination): credit counter, inc/dec, saturation, ovf flag.
// - Top: round-robin picker, FSM, output flops.
// TESTING
// - Reset then req_vld_q=5'b00001 held, no grant -> pops to dest0 in cycles 1,2; third cycle
//   no pop; req_pq=5'b00001 two cycles then 0; sched_cred[0]=0.
// - Then grant[0]=1 one cycle -> cred[0]=1 next cycle, one further pop/request to dest0.
// - req_vld_q=5'b11111 continuous, grant each dest 1 cycle after its request -> grants rotate
//   0,1,2,3,4,0...; each dest issued once per 5 cycles; no ovf.
// - req_atom_q[2]=1 with cred[2]=1 -> dest2 skipped; after one grant[2] -> req_pq=5'b00100
//   atom=1, next cycle 5'b00100 atom=0, cred[2]=0, other dests not requested in between.
// - Issue and grant on dest1 same cycle at cred=1 -> cred[1] stays 1; grant[3] at cred=2 ->
//   cred stays 2, sched_err_ovf=1 and sticky until reset.
// - arst_l low during ATOM2 (after first atomic packet) -> req_pq=0, state IDLE, all creds=2
//   immediately, no second packet issued after release.

Source files
------------

// File: rtl/pcx_sched_pkg.sv
// Shared constants, types and helpers for the per-core PCX request scheduler.
package pcx_sched_pkg;

    localparam int unsigned NDEST    = 5;
    localparam int unsigned CRED_MAX = 2;
    localparam int unsigned CW       = 2;
    localparam int unsigned PTR_W    = $clog2(NDEST);

    // Destination indices on the PCX request vector
    localparam int unsigned DEST_L2B0 = 0;
    localparam int unsigned DEST_L2B1 = 1;
    localparam int unsigned DEST_L2B2 = 2;
    localparam int unsigned DEST_L2B3 = 3;
    localparam int unsigned DEST_IO   = 4;

    typedef logic [PTR_W-1:0] dest_idx_t;

    typedef enum logic [0:0] {
        IDLE,
        ATOM2
    } sched_state_e;

    // Next destination index, wrapping at NDEST
    function automatic dest_idx_t next_dest(input dest_idx_t d);
        return (d == dest_idx_t'(NDEST - 1)) ? dest_idx_t'(0) : dest_idx_t'(d + dest_idx_t'(1));
    endfunction

endpackage

// File: rtl/pcx_cred_ctr.sv
// Per-destination PCX credit counter. Starts full, returns a credit per grant,
// consumes one per issue, saturates at the queue depth and flags a stray grant.
module pcx_cred_ctr
    import pcx_sched_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          grant_i,
    input  logic          issue_i,
    output logic [CW-1:0] cred_o,
    output logic          ovf_o
);

    logic [CW-1:0] cred_d, cred_q;
    logic          ovf_d, ovf_q;

    // Credit next-state: grant and issue in the same cycle cancel out
    always_comb begin
        cred_d = cred_q;
        ovf_d  = ovf_q;
        case ({grant_i, issue_i})
            2'b10: begin
                if (cred_q == CW'(CRED_MAX)) begin
                    ovf_d = 1'b1;
                end else begin
                    cred_d = cred_q + CW'(1);
                end
            end
            2'b01: begin
                // Eligibility keeps issue away from an empty counter; guard anyway
                if (cred_q != '0) begin
                    cred_d = cred_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Credit and sticky overflow state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cred_q <= CW'(CRED_MAX);
            ovf_q  <= 1'b0;
        end else begin
            cred_q <= cred_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cred_o = cred_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/pcx_req_sched.sv
// Per-SPARC-core PCX request scheduler: round-robin pick among destinations
// with credit, two-cycle sequencing of atomic pairs, registered PCX request.
module pcx_req_sched
    import pcx_sched_pkg::*;
(
    input  logic                rclk,
    input  logic                arst_l,
    input  logic [NDEST-1:0]    req_vld_q,
    input  logic [NDEST-1:0]    req_atom_q,
    input  logic [NDEST-1:0]    pcx_spc_grant_pa,
    output logic [NDEST-1:0]    sched_pop,
    output logic [NDEST-1:0]    spc_pcx_req_pq,
    output logic                spc_pcx_atom_pq,
    output logic [NDEST*CW-1:0] sched_cred,
    output logic                sched_err_ovf
);

    logic [CW-1:0]    cred [NDEST];
    logic [NDEST-1:0] ovf_vec;
    logic [NDEST-1:0] elig;
    logic             win_vld;
    dest_idx_t        win_idx;
    logic [NDEST-1:0] pop_vec;
    logic             atom_first;

    sched_state_e     state_d, state_q;
    dest_idx_t        rr_ptr_d, rr_ptr_q;
    dest_idx_t        atom_dest_d, atom_dest_q;
    logic [NDEST-1:0] req_pq_d, req_pq_q;
    logic             atom_pq_d, atom_pq_q;

    for (genvar g = 0; g < NDEST; g++) begin : g_cred
        pcx_cred_ctr u_cred (
            .clk_i   (rclk),
            .rst_ni  (arst_l),
            .grant_i (pcx_spc_grant_pa[g]),
            .issue_i (sched_pop[g]),
            .cred_o  (cred[g]),
            .ovf_o   (ovf_vec[g])
        );
        assign sched_cred[g*CW +: CW] = cred[g];
    end

    assign sched_err_ovf = |ovf_vec;

    // Eligibility from registered credits only; an atomic needs room for both packets
    always_comb begin
        elig = '0;
        for (int d = 0; d < NDEST; d++) begin
            elig[d] = req_vld_q[d] &
                      (req_atom_q[d] ? (cred[d] == CW'(CRED_MAX)) : (cred[d] != '0));
        end
    end

    // Round-robin search starting one past the last winner
    always_comb begin
        dest_idx_t idx;
        win_vld = 1'b0;
        win_idx = rr_ptr_q;
        idx     = next_dest(rr_ptr_q);
        for (int k = 0; k < NDEST; k++) begin
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
            idx = next_dest(idx);
        end
    end

    // FSM next-state and pop selection; ATOM2 re-issues to the latched destination
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        atom_dest_d = atom_dest_q;
        atom_first  = 1'b0;
        pop_vec     = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    pop_vec[win_idx] = 1'b1;
                    rr_ptr_d         = win_idx;
                    if (req_atom_q[win_idx]) begin
                        atom_first  = 1'b1;
                        atom_dest_d = win_idx;
                        state_d     = ATOM2;
                    end
                end
            end
            ATOM2: begin
                pop_vec[atom_dest_q] = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_pq_d  = pop_vec;
        atom_pq_d = atom_first;
    end

    // Pop is combinational but must stay quiet while reset is held
    assign sched_pop = pop_vec & {NDEST{arst_l}};

    // Scheduler state and registered PCX request outputs
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            atom_dest_q <= '0;
            req_pq_q    <= '0;
            atom_pq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            atom_dest_q <= atom_dest_d;
            req_pq_q    <= req_pq_d;
            atom_pq_q   <= atom_pq_d;
        end
    end

    assign spc_pcx_req_pq  = req_pq_q;
    assign spc_pcx_atom_pq = atom_pq_q;

endmodule
